// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot elevator scheduler.
package parking_pkg;

   localparam int unsigned FLOORS  = 7;
   localparam int unsigned FLOOR_W = 3;
   localparam int unsigned PLATE_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_UP    = 3'b001,
      ST_PLACE = 3'b010,
      ST_PICK  = 3'b011,
      ST_DOWN  = 3'b100,
      ST_EXIT  = 3'b101,
      ST_ABORT = 3'b110
   } state_e;

   localparam logic JOB_IN  = 1'b0;
   localparam logic JOB_OUT = 1'b1;

   localparam logic SLOT_SUV   = 1'b0;
   localparam logic SLOT_SEDAN = 1'b1;

   typedef struct packed {
      logic               job_type;
      logic [PLATE_W-1:0] plate;
      logic [FLOOR_W-1:0] floor;
      logic               slot;
   } job_t;

   // A request may be served only for a real parking floor that is not flooded.
   function automatic logic floor_eligible(input logic               req,
                                           input logic [FLOOR_W-1:0] floor,
                                           input logic               leakage,
                                           input logic [FLOOR_W-1:0] leakage_floor);
      return req && (floor != '0) && (32'(floor) <= FLOORS) &&
             !(leakage && (floor == leakage_floor));
   endfunction

endpackage

// File: rtl/request_arbiter.sv
// Round-robin arbiter between the park and retrieve requesters with flood masking.
module request_arbiter
   import parking_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               in_req,
   input  logic [FLOOR_W-1:0] in_floor,
   input  logic               out_req,
   input  logic [FLOOR_W-1:0] out_floor,
   input  logic               leakage,
   input  logic [FLOOR_W-1:0] leakage_floor,
   output logic               grant_in,
   output logic               grant_out
);

   logic last_out;
   logic in_ok;
   logic out_ok;

   always_comb begin
      in_ok     = floor_eligible(in_req, in_floor, leakage, leakage_floor);
      out_ok    = floor_eligible(out_req, out_floor, leakage, leakage_floor);
      grant_in  = 1'b0;
      grant_out = 1'b0;
      if (enable) begin
         if (in_ok && out_ok) begin
            grant_in  = last_out;
            grant_out = !last_out;
         end else begin
            grant_in  = in_ok;
            grant_out = out_ok;
         end
      end
   end

   // Pointer starts at "out" so the park side wins the first tie.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_out <= 1'b1;
      end else if (grant_in) begin
         last_out <= 1'b0;
      end else if (grant_out) begin
         last_out <= 1'b1;
      end
   end

endmodule

// File: rtl/elevator_scheduler.sv
// Elevator sequencer: grants park/retrieve jobs, moves one floor per cycle, strobes slot writes.
module elevator_scheduler
   import parking_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               in_req,
   input  logic [PLATE_W-1:0] in_plate,
   input  logic [FLOOR_W-1:0] in_floor,
   input  logic               in_slot,
   output logic               in_ack,
   input  logic               out_req,
   input  logic [PLATE_W-1:0] out_plate,
   input  logic [FLOOR_W-1:0] out_floor,
   input  logic               out_slot,
   output logic               out_ack,
   input  logic               leakage,
   input  logic [FLOOR_W-1:0] leakage_floor,
   output logic [FLOOR_W-1:0] current_floor,
   output logic [PLATE_W-1:0] moving,
   output logic               store_en,
   output logic               clear_en,
   output logic [FLOOR_W-1:0] slot_floor,
   output logic               slot_sel,
   output logic [PLATE_W-1:0] slot_plate,
   output logic               done,
   output logic               aborted,
   output logic               busy,
   output logic [2:0]         curr_state_for_test
);

   state_e state;
   state_e state_nxt;
   job_t   job;
   logic   abort_q;
   logic   grant_in;
   logic   grant_out;
   logic   abort_hit_c;

   request_arbiter u_arb (
      .clock         (clock),
      .reset         (reset),
      .enable        (state == ST_IDLE),
      .in_req        (in_req),
      .in_floor      (in_floor),
      .out_req       (out_req),
      .out_floor     (out_floor),
      .leakage       (leakage),
      .leakage_floor (leakage_floor),
      .grant_in      (grant_in),
      .grant_out     (grant_out)
   );

   // Flooding ahead of the car on the way up cancels the job.
   assign abort_hit_c = leakage && (leakage_floor > current_floor) &&
                        (leakage_floor <= job.floor);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (grant_in || grant_out) state_nxt = ST_UP;
         ST_UP: begin
            if (abort_hit_c) begin
               state_nxt = ST_ABORT;
            end else if ((current_floor + FLOOR_W'(1)) == job.floor) begin
               state_nxt = (job.job_type == JOB_IN) ? ST_PLACE : ST_PICK;
            end
         end
         ST_PLACE: state_nxt = ST_DOWN;
         ST_PICK:  state_nxt = ST_DOWN;
         ST_ABORT: state_nxt = ST_DOWN;
         ST_DOWN:  if (current_floor <= FLOOR_W'(1)) state_nxt = ST_EXIT;
         ST_EXIT:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      store_en            = (state == ST_PLACE);
      clear_en            = (state == ST_PICK);
      done                = (state == ST_EXIT);
      aborted             = (state == ST_EXIT) && abort_q;
      busy                = (state != ST_IDLE);
      slot_floor          = job.floor;
      slot_sel            = job.slot;
      slot_plate          = job.plate;
      curr_state_for_test = state;
   end

   // Job latch, car position and cargo tracking.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_ack        <= 1'b0;
         out_ack       <= 1'b0;
         current_floor <= '0;
         moving        <= '0;
         job           <= '0;
         abort_q       <= 1'b0;
      end else begin
         in_ack  <= grant_in;
         out_ack <= grant_out;
         case (state)
            ST_IDLE: begin
               if (grant_in) begin
                  job.job_type <= JOB_IN;
                  job.plate    <= in_plate;
                  job.floor    <= in_floor;
                  job.slot     <= in_slot;
                  moving       <= in_plate;
                  abort_q      <= 1'b0;
               end else if (grant_out) begin
                  job.job_type <= JOB_OUT;
                  job.plate    <= out_plate;
                  job.floor    <= out_floor;
                  job.slot     <= out_slot;
                  abort_q      <= 1'b0;
               end
            end
            ST_UP: begin
               if (state_nxt == ST_ABORT) abort_q <= 1'b1;
               else                       current_floor <= current_floor + FLOOR_W'(1);
            end
            ST_PLACE: moving <= '0;
            ST_PICK:  moving <= job.plate;
            ST_DOWN:  if (current_floor != '0) current_floor <= current_floor - FLOOR_W'(1);
            ST_EXIT:  moving <= '0;
            default:  ;
         endcase
      end
   end

endmodule
